dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Responder side of the MEM-stage data memory interface.
- Accepts load/store requests from the EX/MEM stage register outputs, drives a synchronous SRAM through a ready handshake, and returns sign- or zero-extended load data.
- Asserts stall so the pipeline holds every stage register and the PC (wren deasserted) until the access completes.
- Flags misaligned and illegal accesses without touching memory.

Parameters:
- ADDR_W, 14, SRAM word-address width; the SRAM holds 2^ADDR_W 32-bit words.
- TIMEOUT, 255, maximum BUSY cycles waiting for sram_ready before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_read  in  1  load request (dec_mem_read from EX/MEM).
- req_write  in  1  store request (dec_mem_write from EX/MEM).
- req_mode  in  3  access mode: 0 word, 1 byte signed, 2 byte unsigned, 3 half signed, 4 half unsigned, 5-7 illegal.
- req_addr  in  32  byte address (alu_result).
- req_wdata  in  32  store data (mem_write_data).
- rdata  out  32  extended load data, valid in DONE state and held afterwards.
- stall  out  1  combinational; 1 = pipeline must hold.
- fault  out  1  one-cycle pulse on a misaligned access, illegal mode or timeout.
- sram_cs  out  1  SRAM access strobe, registered.
- sram_we  out  1  1 = write, registered.
- sram_be  out  4  byte enables, little-endian, lane n = byte address n, registered.
- sram_addr  out  ADDR_W  word address, equal to req_addr[ADDR_W+1:2].
- sram_wdata  out  32  lane-steered store data.
- sram_rdata  in  32  raw read word, sampled when sram_ready is high.
- sram_ready  in  1  SRAM completes the access on this cycle.

Behaviour:
- Reset (asynchronous, any time, including mid-access):
  - State goes to IDLE.
  - sram_cs, sram_we, fault and stall all 0; sram_be 0; rdata, sram_addr and sram_wdata 0.
  - An in-flight SRAM transaction is abandoned.
- State IDLE:
  - No request: stall=0.
  - Valid request: stall=1 in the same cycle. Next state BUSY; the cs/we/be/addr/wdata registers load on that edge.
  - req_write and req_read both set: treat as a write.
  - Misaligned or illegal request (half with addr[0]=1, word with addr[1:0]!=0, mode 5-7):
    - No SRAM access; stall=0.
    - fault pulses on the next cycle.
    - rdata unchanged; state stays IDLE.
- State BUSY:
  - stall=1 and sram_cs=1; all SRAM outputs held stable.
  - sram_ready=1: capture and extend sram_rdata into rdata (loads only), drop sram_cs on the next edge, go to DONE.
  - Timeout counter reaches TIMEOUT: drop sram_cs, pulse fault, rdata=0, go to DONE.
- State DONE:
  - stall=0 for exactly one cycle, so the pipeline advances at the end of this cycle.
  - Always return to IDLE; the next request is evaluated in IDLE.
- Latency: minimum 2 stall cycles per access (IDLE, then BUSY with ready in its first cycle).
- Write lane steering:
  - Byte: wdata[7:0] replicated to all four lanes; be=1<<addr[1:0].
  - Half: wdata[15:0] replicated to both halves; be=0011 or 1100.
  - Word: be=1111.
- Load extension:
  - Byte: select lane addr[1:0], then sign- or zero-extend to 32 bits.
  - Half: select the half by addr[1], then extend.
  - Word: passed through.
- sram_ready while not in BUSY is ignored.

Optional Feature:
- Macro: DMEM_WRITE_BUFFER_EN.
- Defined:
  - Single-entry posted write buffer.
  - Aligned store in IDLE with the buffer empty: capture into the buffer, stall=0, and the buffer drains to SRAM in the background.
  - Any request while the buffer is draining: stall=1 until the drain completes, then process normally. This guarantees read-after-write ordering.
  - Timeout on a drain: pulses fault.
- Undefined: stores behave exactly as loads (IDLE, BUSY, DONE).

Decomposition:
- Shared package kanade_mem_pkg holds:
  - access-mode constants (MODE_WORD, MODE_BYTE_S, MODE_BYTE_U, MODE_HALF_S, MODE_HALF_U);
  - state encoding (IDLE, BUSY, DONE);
  - the byte-enable width constant.
- One combinational sub-module, dmem_lane_align, owns:
  - write steering and be generation;
  - misalign and illegal detection;
  - load extraction and extension.
- The FSM, timeout counter and optional write buffer stay in dmem_responder.

Test Plan:
- Word store, then load: write addr 0x10 data 0xDEADBEEF with ready after 1 cycle, then read 0x10 → sram_be=1111, sram_addr=4, rdata=0xDEADBEEF, stall high exactly 2 cycles per access.
- Byte loads from word 0x80FF7F01 at addr 0x20:
  - offset 0 signed → 0x00000001;
  - offset 2 signed → 0xFFFFFFFF;
  - offset 3 unsigned → 0x00000080;
  - offset 1 signed → 0x0000007F.
- Half store 0xABCD at addr 0x22 → sram_be=1100, sram_wdata=0xABCDABCD; half-signed load from 0x22 → 0xFFFFABCD.
- Misaligned word read at 0x13 → no sram_cs, stall=0, fault high one cycle, rdata unchanged.
- Timeout: ready never asserted, TIMEOUT=4 → stall high 5 cycles, fault pulse, rdata=0. Reset asserted mid-BUSY → sram_cs and stall drop immediately, state returns to IDLE.
- With DMEM_WRITE_BUFFER_EN: back-to-back store 0x11111111 to 0x40 then load 0x40 → store shows stall=0, load stalls until drain completes, rdata=0x11111111.

Source files
------------

// File: rtl/kanade_mem_pkg.sv
// Shared definitions for the MEM-stage data memory path: access modes,
// responder state encoding and the byte-enable width.
package kanade_mem_pkg;

   localparam int BE_W = 4;

   localparam logic [2:0] MODE_WORD   = 3'd0;
   localparam logic [2:0] MODE_BYTE_S = 3'd1;
   localparam logic [2:0] MODE_BYTE_U = 3'd2;
   localparam logic [2:0] MODE_HALF_S = 3'd3;
   localparam logic [2:0] MODE_HALF_U = 3'd4;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // Byte-offset bits that must be zero for an aligned access in this mode.
   function automatic logic [1:0] align_mask(input logic [2:0] mode);
      logic [1:0] mask;
      case (mode)
         MODE_WORD:                mask = 2'b11;
         MODE_HALF_S, MODE_HALF_U: mask = 2'b01;
         default:                  mask = 2'b00;
      endcase
      return mask;
   endfunction

   function automatic logic mode_legal(input logic [2:0] mode);
      return (mode <= MODE_HALF_U) ? 1'b1 : 1'b0;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: store steering and byte enables, misalign/illegal
// detection, and load lane selection with sign/zero extension.
module dmem_lane_align
   import kanade_mem_pkg::*;
(
   input  logic [2:0]      mode,
   input  logic [1:0]      offset,
   input  logic [31:0]     wdata,
   output logic [BE_W-1:0] be,
   output logic [31:0]     wdata_lane,
   output logic            bad,
   input  logic [2:0]      ld_mode,
   input  logic [1:0]      ld_offset,
   input  logic [31:0]     raw,
   output logic [31:0]     ld_data
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Store side: byte enables, replicated store data and the access check.
   always_comb begin
      be         = 4'b0000;
      wdata_lane = wdata;
      bad        = (|(offset & align_mask(mode))) | ~mode_legal(mode);
      case (mode)
         MODE_WORD: be = 4'b1111;
         MODE_BYTE_S, MODE_BYTE_U: begin
            be         = 4'b0001 << offset;
            wdata_lane = {4{wdata[7:0]}};
         end
         MODE_HALF_S, MODE_HALF_U: begin
            be         = offset[1] ? 4'b1100 : 4'b0011;
            wdata_lane = {2{wdata[15:0]}};
         end
         default: be = 4'b0000;
      endcase
   end

   // Load side: pick the addressed lane, then extend by mode.
   always_comb begin
      case (ld_offset)
         2'd0:    byte_s = raw[7:0];
         2'd1:    byte_s = raw[15:8];
         2'd2:    byte_s = raw[23:16];
         2'd3:    byte_s = raw[31:24];
         default: byte_s = raw[7:0];
      endcase
      if (ld_offset[1]) begin
         half_s = raw[31:16];
      end else begin
         half_s = raw[15:0];
      end
      case (ld_mode)
         MODE_WORD:   ld_data = raw;
         MODE_BYTE_S: ld_data = {{24{byte_s[7]}}, byte_s};
         MODE_BYTE_U: ld_data = {24'd0, byte_s};
         MODE_HALF_S: ld_data = {{16{half_s[15]}}, half_s};
         MODE_HALF_U: ld_data = {16'd0, half_s};
         default:     ld_data = 32'd0;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory responder: SRAM handshake FSM, timeout and stall.
// Define DMEM_WRITE_BUFFER_EN for a single-entry posted write buffer.
module dmem_responder
   import kanade_mem_pkg::*;
#(
   parameter int ADDR_W  = 14,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_read,
   input  logic              req_write,
   input  logic [2:0]        req_mode,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic [31:0]       rdata,
   output logic              stall,
   output logic              fault,
   output logic              sram_cs,
   output logic              sram_we,
   output logic [BE_W-1:0]   sram_be,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [31:0]       sram_wdata,
   input  logic [31:0]       sram_rdata,
   input  logic              sram_ready
);

   localparam int               CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic             TO_EN   = (TIMEOUT > 0) ? 1'b1 : 1'b0;

   logic [1:0]        state_r;
   logic [2:0]        mode_r;
   logic [1:0]        off_r;
   logic              load_r;
   logic [CNT_W-1:0]  cnt_r;
   logic              fault_r;
   logic [31:0]       rdata_r;
   logic              cs_r;
   logic              we_r;
   logic [BE_W-1:0]   be_r;
   logic [ADDR_W-1:0] addr_r;
   logic [31:0]       wdata_r;

   logic              req_any_s, idle_s, busy_s, bad_s;
   logic              accept_s, post_s, reject_s, active_s, hold_s;
   logic              timeout_s, done_s;
   logic [BE_W-1:0]   be_s;
   logic [31:0]       wlane_s, ld_data_s;
   logic              unused_s;

   dmem_lane_align u_lane_align (
      .mode       (req_mode),
      .offset     (req_addr[1:0]),
      .wdata      (req_wdata),
      .be         (be_s),
      .wdata_lane (wlane_s),
      .bad        (bad_s),
      .ld_mode    (mode_r),
      .ld_offset  (off_r),
      .raw        (sram_rdata),
      .ld_data    (ld_data_s)
   );

   assign req_any_s = req_read | req_write;
   assign idle_s    = (state_r == IDLE);
   assign busy_s    = (state_r == BUSY);
   assign unused_s  = ^req_addr[31:ADDR_W+2];

`ifdef DMEM_WRITE_BUFFER_EN
   logic drain_r;

   // A pending drain blocks every new request so loads see the posted store.
   assign post_s   = idle_s & req_write & ~bad_s & ~drain_r;
   assign accept_s = idle_s & req_read & ~req_write & ~bad_s & ~drain_r;
   assign reject_s = idle_s & req_any_s & bad_s & ~drain_r;
   assign active_s = busy_s | drain_r;
   assign hold_s   = drain_r & req_any_s;

   // Posted-store drain flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         drain_r <= 1'b0;
      end else if (post_s) begin
         drain_r <= 1'b1;
      end else if (drain_r & done_s) begin
         drain_r <= 1'b0;
      end else begin
         drain_r <= drain_r;
      end
   end
`else
   assign post_s   = 1'b0;
   assign accept_s = idle_s & req_any_s & ~bad_s;
   assign reject_s = idle_s & req_any_s & bad_s;
   assign active_s = busy_s;
   assign hold_s   = 1'b0;
`endif

   assign timeout_s = active_s & ~sram_ready & TO_EN & (cnt_r == TO_LAST);
   assign done_s    = active_s & (sram_ready | timeout_s);
   assign stall     = reset_n & (busy_s | accept_s | hold_s);

   // Access FSM and the one-cycle fault pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
         fault_r <= 1'b0;
      end else begin
         fault_r <= reject_s | timeout_s;
         case (state_r)
            IDLE:    state_r <= accept_s ? BUSY : IDLE;
            BUSY:    state_r <= done_s ? DONE : BUSY;
            DONE:    state_r <= IDLE;
            default: state_r <= IDLE;
         endcase
      end
   end

   // SRAM request registers, held stable until the access completes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cs_r    <= 1'b0;
         we_r    <= 1'b0;
         be_r    <= 4'b0000;
         addr_r  <= '0;
         wdata_r <= 32'd0;
         mode_r  <= 3'd0;
         off_r   <= 2'd0;
         load_r  <= 1'b0;
      end else if (accept_s | post_s) begin
         cs_r    <= 1'b1;
         we_r    <= req_write;
         be_r    <= be_s;
         addr_r  <= req_addr[ADDR_W+1:2];
         wdata_r <= wlane_s;
         mode_r  <= req_mode;
         off_r   <= req_addr[1:0];
         load_r  <= ~req_write;
      end else if (done_s) begin
         cs_r    <= 1'b0;
      end else begin
         cs_r    <= cs_r;
      end
   end

   // Wait-cycle counter for the ready timeout.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_r <= '0;
      end else if (accept_s | post_s) begin
         cnt_r <= '0;
      end else if (active_s & ~done_s) begin
         cnt_r <= cnt_r + CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Load result capture; a timed-out access returns zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdata_r <= 32'd0;
      end else if (busy_s & sram_ready & load_r) begin
         rdata_r <= ld_data_s;
      end else if (busy_s & timeout_s) begin
         rdata_r <= 32'd0;
      end else begin
         rdata_r <= rdata_r;
      end
   end

   assign rdata      = rdata_r;
   assign fault      = fault_r;
   assign sram_cs    = cs_r;
   assign sram_we    = we_r;
   assign sram_be    = be_r;
   assign sram_addr  = addr_r;
   assign sram_wdata = wdata_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Table-driven bench for dmem_responder with a small SRAM model and a
// scoreboard queue of expected load results.
module tb_dmem_responder;
   import kanade_mem_pkg::*;

   localparam int ADDR_W  = 14;
   localparam int TIMEOUT = 4;
`ifdef DMEM_WRITE_BUFFER_EN
   localparam bit WB = 1'b1;
`else
   localparam bit WB = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset_n;
   logic              req_read, req_write;
   logic [2:0]        req_mode;
   logic [31:0]       req_addr, req_wdata;
   logic [31:0]       rdata;
   logic              stall, fault;
   logic              sram_cs, sram_we;
   logic [3:0]        sram_be;
   logic [ADDR_W-1:0] sram_addr;
   logic [31:0]       sram_wdata, sram_rdata;
   logic              sram_ready;
   logic              ready_en;

   logic [31:0] mem [0:255];
   int          cs_cycles = 0;
   logic [3:0]  last_be;
   logic [ADDR_W-1:0] last_addr;
   logic [31:0] last_wdata;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] sb_q[$];

   typedef struct {
      bit          rd;
      bit          wr;
      logic [2:0]  mode;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          rdy;
      logic [31:0] exp_rdata;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      int          exp_stall;
      int          exp_cs;
      int          exp_fault;
   } vec_t;

   vec_t vt[21];

   dmem_responder #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_read   (req_read),
      .req_write  (req_write),
      .req_mode   (req_mode),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rdata      (rdata),
      .stall      (stall),
      .fault      (fault),
      .sram_cs    (sram_cs),
      .sram_we    (sram_we),
      .sram_be    (sram_be),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata),
      .sram_ready (sram_ready)
   );

   always #5 clk = ~clk;

   assign sram_ready = sram_cs & ready_en;
   assign sram_rdata = mem[sram_addr[7:0]];

   always @(posedge clk) begin
      if (sram_cs && sram_ready && sram_we) begin
         for (int i = 0; i < 4; i++) begin
            if (sram_be[i]) mem[sram_addr[7:0]][8*i +: 8] <= sram_wdata[8*i +: 8];
         end
      end
   end

   always @(posedge clk) begin
      if (sram_cs) begin
         cs_cycles  <= cs_cycles + 1;
         last_be    <= sram_be;
         last_addr  <= sram_addr;
         last_wdata <= sram_wdata;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(bit rd, bit wr, logic [2:0] mode, logic [31:0] addr,
                               logic [31:0] wdata, bit rdy, logic [31:0] exp_rdata,
                               logic [3:0] exp_be, logic [31:0] exp_wdata,
                               int exp_stall, int exp_cs, int exp_fault);
      vec_t v;
      v.rd = rd; v.wr = wr; v.mode = mode; v.addr = addr; v.wdata = wdata; v.rdy = rdy;
      v.exp_rdata = exp_rdata; v.exp_be = exp_be; v.exp_wdata = exp_wdata;
      v.exp_stall = exp_stall; v.exp_cs = exp_cs; v.exp_fault = exp_fault;
      return v;
   endfunction

   // Caller is mid-cycle (after a negedge). Request is held through the edge
   // that ends the cycle in which stall drops, as the pipeline would.
   task automatic do_access(input vec_t v, input int idx);
      int          n, fcnt, cs0, exp_stall;
      logic [31:0] got, exp_rd;
      cs0       = cs_cycles;
      req_read  = v.rd;
      req_write = v.wr;
      req_mode  = v.mode;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      ready_en  = v.rdy;
      sb_q.push_back(v.exp_rdata);
      #1;
      n = 0;
      fcnt = 0;
      while (stall && n < 50) begin
         n++;
         fcnt += int'(fault);
         @(negedge clk);
         #1;
      end
      got = rdata;
      fcnt += int'(fault);
      @(negedge clk);
      req_read  = 1'b0;
      req_write = 1'b0;
      #1;
      fcnt += int'(fault);
      repeat (2) begin
         @(negedge clk);
         #1;
         fcnt += int'(fault);
      end
      exp_stall = (v.wr && v.exp_fault == 0 && WB) ? 0 : v.exp_stall;
      exp_rd = sb_q.pop_front();
      check($sformatf("v%0d stall_cycles", idx), n, exp_stall);
      check($sformatf("v%0d fault_pulses", idx), fcnt, v.exp_fault);
      check($sformatf("v%0d rdata", idx), got, exp_rd);
      check($sformatf("v%0d cs_cycles", idx), cs_cycles - cs0, v.exp_cs);
      if (v.exp_cs != 0) begin
         check($sformatf("v%0d sram_be", idx), {28'd0, last_be}, {28'd0, v.exp_be});
         check($sformatf("v%0d sram_addr", idx), {18'd0, last_addr}, {18'd0, v.addr[15:2]});
      end
      if (v.wr && v.exp_cs != 0) begin
         check($sformatf("v%0d sram_wdata", idx), last_wdata, v.exp_wdata);
      end
   endtask

   initial begin
      int n;
      reset_n = 1'b0;
      req_read = 1'b0; req_write = 1'b0; req_mode = 3'd0;
      req_addr = 32'd0; req_wdata = 32'd0; ready_en = 1'b1;
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;

      //          rd wr mode         addr   wdata         rdy exp_rdata     be       exp_wdata     st cs f
      vt[0]  = mk(1, 0, MODE_WORD,   'h10, 32'h0,        1, 32'hDEADBEEF, 4'b1111, 32'h0,        2, 1, 0);
      vt[1]  = mk(0, 1, MODE_WORD,   'h20, 32'h80FF7F01, 1, 32'hDEADBEEF, 4'b1111, 32'h80FF7F01, 2, 1, 0);
      vt[2]  = mk(1, 0, MODE_BYTE_S, 'h20, 32'h0,        1, 32'h00000001, 4'b0001, 32'h0,        2, 1, 0);
      vt[3]  = mk(1, 0, MODE_BYTE_S, 'h22, 32'h0,        1, 32'hFFFFFFFF, 4'b0100, 32'h0,        2, 1, 0);
      vt[4]  = mk(1, 0, MODE_BYTE_U, 'h23, 32'h0,        1, 32'h00000080, 4'b1000, 32'h0,        2, 1, 0);
      vt[5]  = mk(1, 0, MODE_BYTE_S, 'h21, 32'h0,        1, 32'h0000007F, 4'b0010, 32'h0,        2, 1, 0);
      vt[6]  = mk(0, 1, MODE_HALF_S, 'h22, 32'h0000ABCD, 1, 32'h0000007F, 4'b1100, 32'hABCDABCD, 2, 1, 0);
      vt[7]  = mk(1, 0, MODE_HALF_S, 'h22, 32'h0,        1, 32'hFFFFABCD, 4'b1100, 32'h0,        2, 1, 0);
      vt[8]  = mk(1, 0, MODE_HALF_U, 'h20, 32'h0,        1, 32'h00007F01, 4'b0011, 32'h0,        2, 1, 0);
      vt[9]  = mk(1, 0, MODE_WORD,   'h13, 32'h0,        1, 32'h00007F01, 4'b0000, 32'h0,        0, 0, 1);
      vt[10] = mk(1, 0, 3'd5,        'h10, 32'h0,        1, 32'h00007F01, 4'b0000, 32'h0,        0, 0, 1);
      vt[11] = mk(1, 0, MODE_HALF_S, 'h21, 32'h0,        1, 32'h00007F01, 4'b0000, 32'h0,        0, 0, 1);
      vt[12] = mk(0, 1, MODE_BYTE_U, 'h31, 32'h000000A5, 1, 32'h00007F01, 4'b0010, 32'hA5A5A5A5, 2, 1, 0);
      vt[13] = mk(1, 1, MODE_WORD,   'h34, 32'h12345678, 1, 32'h00007F01, 4'b1111, 32'h12345678, 2, 1, 0);
      vt[14] = mk(1, 0, MODE_WORD,   'h30, 32'h0,        1, 32'h0000A500, 4'b1111, 32'h0,        2, 1, 0);
      vt[15] = mk(1, 0, MODE_WORD,   'h34, 32'h0,        1, 32'h12345678, 4'b1111, 32'h0,        2, 1, 0);
      vt[16] = mk(1, 0, MODE_WORD,   'h10, 32'h0,        0, 32'h00000000, 4'b1111, 32'h0,        5, 4, 1);
      vt[17] = mk(1, 0, MODE_WORD,   'h10, 32'h0,        1, 32'hDEADBEEF, 4'b1111, 32'h0,        2, 1, 0);
      vt[18] = mk(0, 1, MODE_HALF_U, 'h23, 32'h0000FFFF, 1, 32'hDEADBEEF, 4'b0000, 32'h0,        0, 0, 1);
      vt[19] = mk(1, 0, MODE_HALF_U, 'h12, 32'h0,        1, 32'h0000DEAD, 4'b1100, 32'h0,        2, 1, 0);
      vt[20] = mk(1, 0, MODE_BYTE_S, 'h13, 32'h0,        1, 32'hFFFFFFDE, 4'b1000, 32'h0,        2, 1, 0);

      repeat (2) @(negedge clk);
      #1;
      check("reset sram_cs", {31'd0, sram_cs}, 32'd0);
      check("reset sram_we", {31'd0, sram_we}, 32'd0);
      check("reset sram_be", {28'd0, sram_be}, 32'd0);
      check("reset sram_addr", {18'd0, sram_addr}, 32'd0);
      check("reset sram_wdata", sram_wdata, 32'd0);
      check("reset rdata", rdata, 32'd0);
      check("reset fault", {31'd0, fault}, 32'd0);
      check("reset stall", {31'd0, stall}, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      #1;

      // Preload word 0x10 with a store, then run the table.
      do_access(mk(0, 1, MODE_WORD, 'h10, 32'hDEADBEEF, 1, 32'h0, 4'b1111, 32'hDEADBEEF, 2, 1, 0), 99);
      for (int i = 0; i < 21; i++) do_access(vt[i], i);

      // Reset in the middle of a BUSY access.
      req_read = 1'b1; req_mode = MODE_WORD; req_addr = 32'h10; ready_en = 1'b0;
      @(negedge clk);
      #1;
      check("midreset busy sram_cs", {31'd0, sram_cs}, 32'd1);
      reset_n = 1'b0;
      #1;
      check("midreset sram_cs", {31'd0, sram_cs}, 32'd0);
      check("midreset stall", {31'd0, stall}, 32'd0);
      check("midreset rdata", rdata, 32'd0);
      @(negedge clk);
      req_read = 1'b0;
      ready_en = 1'b1;
      reset_n  = 1'b1;
      #1;
      check("postreset stall", {31'd0, stall}, 32'd0);
      do_access(mk(1, 0, MODE_WORD, 'h10, 32'h0, 1, 32'hDEADBEEF, 4'b1111, 32'h0, 2, 1, 0), 100);

`ifdef DMEM_WRITE_BUFFER_EN
      // Posted store immediately followed by a load of the same word.
      req_write = 1'b1; req_mode = MODE_WORD; req_addr = 32'h40; req_wdata = 32'h11111111;
      #1;
      check("wb store stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      req_write = 1'b0; req_read = 1'b1;
      #1;
      n = 0;
      while (stall && n < 50) begin
         n++;
         @(negedge clk);
         #1;
      end
      check("wb load stall_cycles", n, 3);
      check("wb load rdata", rdata, 32'h11111111);
      @(negedge clk);
      req_read = 1'b0;
      repeat (2) @(negedge clk);
`else
      n = 0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
